rns_mod_reducer_9_bit: RTL and testbench

RNS_MOD_REDUCER_9_BIT -- requirements
Module: rns_mod_reducer_9_bit

---
 rtl/rns_mod_reducer_9_bit.sv | 106 ++++++++++
 tb/tb_rns_mod_reducer_9_bit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rns_mod_reducer_9_bit.sv
// Sequential restoring divider: reduces a 9-bit product modulo MODULUS, one quotient
// bit per cycle MSB first, and returns both residue and quotient over a valid/ready pair.
module rns_mod_reducer_9_bit #(
   parameter int MODULUS = 61
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] product,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] residue,
   output logic [8:0] quotient
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [6:0] MOD7 = 7'(MODULUS);

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   logic [8:0] r_shift;
   logic [6:0] r_rem;
   logic [8:0] r_quo;
   logic [3:0] r_cnt;
   logic       r_in_ready;
   logic [5:0] r_residue;
   logic [8:0] r_quotient;

   logic [6:0] w_t;
   logic       w_ge;
   logic [6:0] w_rem_next;
   logic [8:0] w_quo_next;
   logic       w_in_hs;
   logic       w_out_hs;

   // One restoring step: the remainder stays below MODULUS, so t never exceeds 2*MODULUS-1.
   assign w_t        = {r_rem[5:0], r_shift[8]};
   assign w_ge       = (w_t >= MOD7);
   assign w_rem_next = w_ge ? (w_t - MOD7) : w_t;
   assign w_quo_next = {r_quo[7:0], w_ge};

   assign w_in_hs  = (r_state == ST_IDLE) && r_in_ready && in_valid;
   assign w_out_hs = (r_state == ST_DONE) && out_ready;

   always_comb begin
      // NOTE: default first so every path assigns the next state and no latch is inferred.
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_in_hs) w_state_next = ST_CALC;
         ST_CALC: if (r_cnt == 4'd0) w_state_next = ST_DONE;
         ST_DONE: if (w_out_hs) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_cnt      <= '0;
         r_in_ready <= 1'b0;
         r_residue  <= '0;
         r_quotient <= '0;
      end else begin
         r_state    <= w_state_next;
         // Registered so that in_ready stays low through reset and rises one edge after release.
         r_in_ready <= (w_state_next == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_in_hs) begin
                  r_shift <= product;
                  r_rem   <= '0;
                  r_quo   <= '0;
                  r_cnt   <= 4'd8;
               end
            end
            ST_CALC: begin
               r_shift <= {r_shift[7:0], 1'b0};
               r_rem   <= w_rem_next;
               r_quo   <= w_quo_next;
               if (r_cnt == 4'd0) begin
                  // Outputs are held in separate registers so they never show partial results.
                  r_residue  <= w_rem_next[5:0];
                  r_quotient <= w_quo_next;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state == ST_DONE);
   assign residue   = r_residue;
   assign quotient  = r_quotient;

endmodule

// File: tb/tb_rns_mod_reducer_9_bit.sv
// Bench for rns_mod_reducer_9_bit: four instances (moduli 61, 3, 7, 63) driven in lockstep,
// results checked against a queue of expected residue/quotient pairs.
`timescale 1ns/1ps
module tb_rns_mod_reducer_9_bit;

   localparam int NMOD = 4;
   localparam int MODS [NMOD] = '{61, 3, 7, 63};

   typedef struct {
      int p;
      int r [NMOD];
      int q [NMOD];
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [8:0] product;
   logic       out_ready;
   logic       rdy [NMOD];
   logic       ov  [NMOD];
   logic [5:0] res [NMOD];
   logic [8:0] quo [NMOD];

   exp_t sb [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   for (genvar g = 0; g < NMOD; g++) begin : g_dut
      rns_mod_reducer_9_bit #(.MODULUS(MODS[g])) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (rdy[g]),
         .product   (product),
         .out_valid (ov[g]),
         .out_ready (out_ready),
         .residue   (res[g]),
         .quotient  (quo[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input int p);
      exp_t e;
      e.p = p;
      for (int i = 0; i < NMOD; i++) begin
         e.r[i] = p % MODS[i];
         e.q[i] = p / MODS[i];
      end
      return e;
   endfunction

   // Called at a negedge; offers p and returns at the negedge after the handshake edge.
   task automatic send(input int p);
      int budget = 0;
      while (!rdy[0] && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("send_ready", rdy[0], 1);
      in_valid = 1'b1;
      product  = 9'(p);
      @(posedge clk);
      sb.push_back(model(p));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Waits for a result, applies 'stall' cycles of back-pressure, then takes and scores it.
   task automatic receive(input int stall);
      exp_t e;
      int   budget = 0;
      while (!ov[0] && budget < 50) begin
         @(negedge clk);
         budget++;
      end
      check("recv_valid", ov[0], 1);
      out_ready = 1'b0;
      repeat (stall) @(negedge clk);
      if (sb.size() == 0) begin
         check("sb_underflow", sb.size(), 1);
      end else begin
         e = sb.pop_front();
         for (int i = 0; i < NMOD; i++) begin
            check($sformatf("ov_m%0d", MODS[i]), ov[i], 1);
            check($sformatf("res_m%0d_p%0d", MODS[i], e.p), res[i], e.r[i]);
            check($sformatf("quo_m%0d_p%0d", MODS[i], e.p), quo[i], e.q[i]);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_ov", ov[0], 0);
      check("idle_rdy", rdy[0], 1);
   endtask

   initial begin
      logic [5:0] held_res;
      logic [8:0] held_quo;
      in_valid  = 1'b0;
      product   = '0;
      out_ready = 1'b0;
      rst_n     = 1'b0;

      // Reset state, then in_ready rises on the first edge after release.
      repeat (3) @(negedge clk);
      check("rst_rdy", rdy[0], 0);
      check("rst_ov", ov[0], 0);
      check("rst_res", res[0], 0);
      check("rst_quo", quo[0], 0);
      rst_n = 1'b1;
      #1;
      check("rel_rdy_before_edge", rdy[0], 0);
      @(negedge clk);
      check("rel_rdy_after_edge", rdy[0], 1);

      // Latency: counting the handshake edge as edge 1, out_valid is high after edge 10.
      // in_valid stays high with a different product during CALC and must be ignored.
      in_valid = 1'b1;
      product  = 9'd441;
      sb.push_back(model(441));
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) product = 9'd100;
         if (k == 5) begin
            check("calc_rdy", rdy[0], 0);
            check("calc_ov", ov[0], 0);
         end
         if (k == 9) begin
            check("lat_edge9_ov", ov[0], 0);
            in_valid = 1'b0;
         end
         if (k == 10) check("lat_edge10_ov", ov[0], 1);
      end
      receive(0);

      // Boundary values.
      foreach (MODS[i]) begin end
      send(511); receive(0);
      send(0);   receive(0);
      send(60);  receive(0);
      send(183); receive(0);
      send(122); receive(1);

      // Back-pressure: DONE held 20 cycles while in_valid toggles with a new product.
      send(300);
      while (!ov[0]) @(negedge clk);
      held_res = res[0];
      held_quo = quo[0];
      for (int k = 0; k < 20; k++) begin
         in_valid = k[0];
         product  = 9'd5;
         @(negedge clk);
         check("bp_ov", ov[0], 1);
         check("bp_rdy", rdy[0], 0);
         check("bp_res", res[0], held_res);
         check("bp_quo", quo[0], held_quo);
      end
      in_valid = 1'b0;
      receive(0);
      repeat (15) @(negedge clk);
      check("bp_no_extra", ov[0], 0);

      // Reset during the 5th CALC cycle discards the operation.
      in_valid = 1'b1;
      product  = 9'd441;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ov", ov[0], 0);
      check("mid_rst_rdy", rdy[0], 0);
      check("mid_rst_res", res[0], 0);
      check("mid_rst_quo", quo[0], 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_rdy", rdy[0], 1);
      begin
         int seen = 0;
         for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (ov[0]) seen++;
         end
         check("post_rst_no_stale", seen, 0);
      end

      // Full sweep with random back-pressure on all four moduli.
      for (int p = 0; p < 512; p++) begin
         send(p);
         receive(int'($urandom_range(0, 3)));
      end

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
